fc_weight_sequencer: RTL and testbench
======================================

Name: fc_weight_sequencer

Overview:
- Sequences one fully-connected layer pass over the weight memory: steps the row address 0..INPUT_NODES-1 and pairs each row's weights with its input activation.
- Handles the memory's 1-cycle registered read latency by delaying the activation and a valid strobe to line up with returned weights.
- Sits between the activation source (valid/ready), the weight memory (address port) and the downstream MAC array (clear/valid/last strobes).

Parameters:
- DATA_WIDTH, 32, activation word width.
- INPUT_NODES, 100, rows per pass (weight memory depth in rows); legal range 1..2047.
- OUTPUT_NODES, 32, informational only, passed through for downstream sizing; no logic depends on it.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- start  in  1  one-cycle request to begin a pass; sampled only in IDLE.
- busy  out  1  high from the cycle after start is accepted through the DONE cycle inclusive.
- done  out  1  one-cycle pulse at pass completion.
- act_data  in  DATA_WIDTH  activation for the current row index.
- act_valid  in  1  act_data valid.
- act_ready  out  1  sequencer accepts act_data this cycle.
- weight_address  out  11  registered row address to the weight memory.
- mac_act  out  DATA_WIDTH  activation aligned with the weights.
- mac_clear  out  1  one-cycle accumulator clear.
- mac_valid  out  1  weights and mac_act valid this cycle.
- mac_last  out  1  qualifies the mac_valid beat of row INPUT_NODES-1.

Behaviour:
- Reset values:
  - state IDLE.
  - weight_address = INPUT_NODES (park value; out of range, so the memory returns zero weights).
  - row index = 0.
  - busy, done, act_ready, mac_clear, mac_valid, mac_last = 0.
  - mac_act = 0.
- States: IDLE, CLEAR, RUN, DRAIN, DONE.
- IDLE
  - weight_address parked.
  - start=1 goes to CLEAR; start=0 stays in IDLE.
- CLEAR (1 cycle)
  - mac_clear=1, index=0, weight_address=0.
  - Next state: RUN.
- RUN
  - act_ready=1; weight_address equals the current index k.
  - Handshake (act_valid & act_ready) in cycle t:
    - The memory samples address k at the end of cycle t.
    - At that edge: mac_act <= act_data, and mac_valid=1 is driven in cycle t+1.
    - mac_last=1 in cycle t+1 iff k = INPUT_NODES-1.
    - Index increments and weight_address <= k+1 at the same edge.
  - No handshake: weight_address holds, index holds, and mac_valid=0 in the next cycle (bubble).
  - Handshake with k = INPUT_NODES-1: go to DRAIN and park weight_address = INPUT_NODES.
- DRAIN (1 cycle)
  - act_ready=0; the final mac_valid/mac_last beat is presented.
  - Next state: DONE.
- DONE (1 cycle)
  - done=1, busy=1.
  - Next state: IDLE, where busy=0.
- Latency with act_valid held high, start accepted in cycle 0:
  - mac_clear in cycle 1.
  - Handshakes in cycles 2..N+1.
  - mac_valid in cycles 3..N+2.
  - done in cycle N+3.
- Boundary conditions:
  - start while busy (CLEAR..DONE, including the DONE cycle) is ignored; no queuing.
  - act_valid outside RUN is ignored; act_ready=0 outside RUN.
  - INPUT_NODES=1: RUN holds for one handshake only; the first mac_valid beat also has mac_last=1.
  - mac_act holds its last value when mac_valid=0.
  - Index width is 11 bits with no wrap, since INPUT_NODES ≤ 2047.
  - Reset asserted mid-pass immediately returns all outputs to reset values.
  - No done pulse is issued for an aborted pass.

Optional Feature:
- Macro: FC_SEQ_STALL_COUNT_EN.
- Enabled:
  - Adds output stall_cycles (16 bits).
  - Cleared in CLEAR.
  - Increments each RUN cycle with act_valid=0; saturates at 0xFFFF.
  - Holds its value after DONE until the next CLEAR.
  - Reset value 0.
- Disabled: the port and counter are absent; all other behaviour is identical.

Test Plan:
- INPUT_NODES=4, act_valid=1 constant, start pulse at cycle 0:
  - mac_clear in cycle 1.
  - weight_address 0,1,2,3 in cycles 2..5, then 4.
  - mac_valid in cycles 3..6, mac_last in cycle 6, done in cycle 7.
  - busy high in cycles 1..7.
- INPUT_NODES=4, act_valid low in cycles 3 and 4:
  - weight_address holds 1 through cycles 3..5.
  - mac_valid=0 in cycles 4 and 5.
  - mac_act sequence matches act_data values A0..A3 in order.
  - done in cycle 9; with FC_SEQ_STALL_COUNT_EN, stall_cycles=2.
- start pulsed again during RUN and during the DONE cycle:
  - Ignored; exactly one done pulse; no second mac_clear.
- reset asserted at cycle 4 of a pass:
  - Same-cycle (asynchronous) return to reset values: weight_address=INPUT_NODES, busy=0.
  - No done pulse.
  - A new start then completes normally.
- INPUT_NODES=1:
  - Single handshake; mac_valid and mac_last both high in cycle 3.
  - done in cycle 4.
- Idle with act_valid=1:
  - act_ready=0, mac_valid=0, weight_address=INPUT_NODES, memory weights read as 0.

Source files
------------

// File: rtl/fc_weight_sequencer.sv
// fc_weight_sequencer: steps the weight-memory row address across one
// fully-connected layer pass and pairs each row with its input activation.
// The weight memory has a 1-cycle registered read, so the accepted activation
// and a valid strobe are registered to line up with the returned weights.
// Optional feature macro: FC_SEQ_STALL_COUNT_EN (adds o_stall_cycles).
module fc_weight_sequencer #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned INPUT_NODES  = 100,
  parameter int unsigned OUTPUT_NODES = 32
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_start,
  output logic                  o_busy,
  output logic                  o_done,
  input  logic [DATA_WIDTH-1:0] i_act_data,
  input  logic                  i_act_valid,
  output logic                  o_act_ready,
  output logic [10:0]           o_weight_address,
  output logic [DATA_WIDTH-1:0] o_mac_act,
  output logic                  o_mac_clear,
  output logic                  o_mac_valid,
`ifdef FC_SEQ_STALL_COUNT_EN
  output logic [15:0]           o_stall_cycles,
`endif
  output logic                  o_mac_last
);

  // Park address is one past the last row, so the memory returns zero weights.
  localparam logic [10:0] Park    = 11'(INPUT_NODES);
  localparam logic [10:0] LastRow = 11'(INPUT_NODES - 1);

  // Elaboration-time guard on the configuration; OUTPUT_NODES is informational.
  if (INPUT_NODES == 0 || INPUT_NODES > 2047 || OUTPUT_NODES == 0) begin : g_param_check
    $error("fc_weight_sequencer: illegal INPUT_NODES/OUTPUT_NODES");
  end

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StRun,
    StDrain,
    StDone
  } state_e;

  state_e                r_state;
  state_e                w_state_next;
  // During CLEAR/RUN the address register is also the row index.
  logic [10:0]           r_addr;
  logic [10:0]           w_addr_next;
  logic [DATA_WIDTH-1:0] r_mac_act;
  logic                  r_mac_valid;
  logic                  r_mac_last;
  logic                  w_handshake;
  logic                  w_last_row;

  assign w_handshake = (r_state == StRun) && i_act_valid;
  assign w_last_row  = (r_addr == LastRow);

  // State and address register.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= StIdle;
      r_addr  <= Park;
    end else begin
      r_state <= w_state_next;
      r_addr  <= w_addr_next;
    end
  end

  // Next-state and next-address decode.
  always_comb begin
    w_state_next = r_state;
    w_addr_next  = r_addr;
    unique case (r_state)
      StIdle: begin
        if (i_start) begin
          w_state_next = StClear;
          w_addr_next  = 11'd0;
        end
      end
      StClear: begin
        w_state_next = StRun;
      end
      StRun: begin
        if (w_handshake) begin
          // Stepping past the last row lands exactly on the park address.
          w_addr_next = r_addr + 11'd1;
          if (w_last_row) begin
            w_state_next = StDrain;
          end
        end
      end
      StDrain: begin
        w_state_next = StDone;
      end
      StDone: begin
        w_state_next = StIdle;
      end
      default: begin
        w_state_next = StIdle;
        w_addr_next  = Park;
      end
    endcase
  end

  // Activation and strobes delayed one cycle to meet the registered weights.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_mac_act   <= '0;
      r_mac_valid <= 1'b0;
      r_mac_last  <= 1'b0;
    end else begin
      r_mac_valid <= w_handshake;
      r_mac_last  <= w_handshake && w_last_row;
      if (w_handshake) begin
        r_mac_act <= i_act_data;
      end
    end
  end

`ifdef FC_SEQ_STALL_COUNT_EN
  logic [15:0] r_stall;

  // Saturating count of RUN cycles with no activation offered.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_stall <= 16'd0;
    end else if (r_state == StClear) begin
      r_stall <= 16'd0;
    end else if ((r_state == StRun) && !i_act_valid && (r_stall != 16'hFFFF)) begin
      r_stall <= r_stall + 16'd1;
    end
  end

  assign o_stall_cycles = r_stall;
`endif

  assign o_busy           = (r_state != StIdle);
  assign o_done           = (r_state == StDone);
  assign o_act_ready      = (r_state == StRun);
  assign o_mac_clear      = (r_state == StClear);
  assign o_weight_address = r_addr;
  assign o_mac_act        = r_mac_act;
  assign o_mac_valid      = r_mac_valid;
  assign o_mac_last       = r_mac_last;

endmodule

// File: tb/tb_fc_weight_sequencer.sv
// Bench for fc_weight_sequencer: directed vector table and hand-written
// corner sequences on INPUT_NODES=4 and =1, then randomized traffic on
// INPUT_NODES=7 against a pass-level reference model with a weight memory.
module tb_fc_weight_sequencer;

  localparam int N7 = 7;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        act_valid;
  logic [31:0] act_data;

  logic b4, d4, r4, c4, v4, l4;
  logic [10:0] a4;
  logic [31:0] m4;
  logic b1, d1, r1, c1, v1, l1;
  logic [10:0] a1;
  logic [31:0] m1;
  logic b7, d7, r7, c7, v7, l7;
  logic [10:0] a7;
  logic [31:0] m7;
  logic [31:0] mem7_q;
`ifdef FC_SEQ_STALL_COUNT_EN
  logic [15:0] s4, s1, s7;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fc_weight_sequencer #(.DATA_WIDTH(32), .INPUT_NODES(4), .OUTPUT_NODES(32)) dut4 (
    .i_clk(clk), .i_reset(rst), .i_start(start), .o_busy(b4), .o_done(d4),
    .i_act_data(act_data), .i_act_valid(act_valid), .o_act_ready(r4),
    .o_weight_address(a4), .o_mac_act(m4), .o_mac_clear(c4), .o_mac_valid(v4),
`ifdef FC_SEQ_STALL_COUNT_EN
    .o_stall_cycles(s4),
`endif
    .o_mac_last(l4)
  );

  fc_weight_sequencer #(.DATA_WIDTH(32), .INPUT_NODES(1), .OUTPUT_NODES(32)) dut1 (
    .i_clk(clk), .i_reset(rst), .i_start(start), .o_busy(b1), .o_done(d1),
    .i_act_data(act_data), .i_act_valid(act_valid), .o_act_ready(r1),
    .o_weight_address(a1), .o_mac_act(m1), .o_mac_clear(c1), .o_mac_valid(v1),
`ifdef FC_SEQ_STALL_COUNT_EN
    .o_stall_cycles(s1),
`endif
    .o_mac_last(l1)
  );

  fc_weight_sequencer #(.DATA_WIDTH(32), .INPUT_NODES(N7), .OUTPUT_NODES(32)) dut7 (
    .i_clk(clk), .i_reset(rst), .i_start(start), .o_busy(b7), .o_done(d7),
    .i_act_data(act_data), .i_act_valid(act_valid), .o_act_ready(r7),
    .o_weight_address(a7), .o_mac_act(m7), .o_mac_clear(c7), .o_mac_valid(v7),
`ifdef FC_SEQ_STALL_COUNT_EN
    .o_stall_cycles(s7),
`endif
    .o_mac_last(l7)
  );

  function automatic logic [31:0] wfun(input int a);
    return (a < N7) ? 32'(a * 17 + 3) : 32'd0;
  endfunction

  // Weight memory for dut7: registered read, zero outside the row range.
  always @(posedge clk) mem7_q <= wfun(int'(a7));

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  typedef struct {
    logic        start;
    logic        valid;
    logic [31:0] data;
    logic        busy;
    logic        done;
    logic        ready;
    logic [10:0] addr;
    logic        clr;
    logic        mv;
    logic        ml;
    logic [31:0] mact;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input logic s, input logic v, input logic [31:0] d, input logic eb,
                         input logic ed, input logic er, input logic [10:0] ea,
                         input logic ec, input logic emv, input logic eml,
                         input logic [31:0] em);
    vec_t x;
    x.start = s; x.valid = v; x.data = d; x.busy = eb; x.done = ed; x.ready = er;
    x.addr = ea; x.clr = ec; x.mv = emv; x.ml = eml; x.mact = em;
    vecs.push_back(x);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; start = 1'b0; act_valid = 1'b0; act_data = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Reference model for dut7: a pass is tracked by cycles since acceptance
  // and rows consumed; mac beats follow their handshake by one cycle.
  int          m_active, m_cyc, m_rows, m_last_hs, m_pv, m_pl, m_prow, m_stall, m_prev_park;
  logic [31:0] m_act;

  function automatic int e_ready();
    return (m_active != 0 && m_cyc >= 2 && m_rows < N7) ? 1 : 0;
  endfunction
  function automatic int e_addr();
    return (m_active != 0 && m_rows < N7) ? m_rows : N7;
  endfunction
  function automatic int e_done();
    return (m_active != 0 && m_rows == N7 && m_cyc == m_last_hs + 2) ? 1 : 0;
  endfunction
  function automatic int e_clear();
    return (m_active != 0 && m_cyc == 1) ? 1 : 0;
  endfunction

  task automatic model_reset();
    m_active = 0; m_cyc = 0; m_rows = 0; m_last_hs = -10; m_pv = 0; m_pl = 0;
    m_prow = 0; m_stall = 0; m_prev_park = 0; m_act = '0;
  endtask

  task automatic model_edge(input logic s, input logic v, input logic [31:0] d);
    int hs, dn, cl, c0;
    hs = (e_ready() != 0 && v) ? 1 : 0;
    dn = e_done();
    cl = e_clear();
    c0 = m_cyc;
    if (cl != 0) m_stall = 0;
    else if (e_ready() != 0 && !v && m_stall < 65535) m_stall++;
    m_prev_park = (e_addr() == N7) ? 1 : 0;
    m_pv = hs;
    m_pl = (hs != 0 && m_rows == N7 - 1) ? 1 : 0;
    m_prow = m_rows;
    if (hs != 0) m_act = d;
    if (m_active != 0) begin
      if (hs != 0) begin
        m_last_hs = c0;
        m_rows++;
      end
      if (dn != 0) m_active = 0;
      else m_cyc = c0 + 1;
    end else if (s) begin
      m_active = 1; m_cyc = 1; m_rows = 0;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int beats, done_cnt, done_cyc;
    rst = 1'b1; start = 1'b0; act_valid = 1'b0; act_data = '0;
    model_reset();
    #1;
    chk("reset busy", b4, 0);
    chk("reset addr", a4, 4);
    chk("reset ready", r4, 0);
    chk("reset mac_valid", v4, 0);
    chk("reset mac_act", m4, 0);
    do_reset();

    // Back-to-back passes: full-rate, then stalls plus ignored start pulses.
    add_vec(1, 1, 32'h100, 0, 0, 0, 4, 0, 0, 0, 32'h000);
    add_vec(0, 1, 32'h101, 1, 0, 0, 0, 1, 0, 0, 32'h000);
    add_vec(0, 1, 32'h102, 1, 0, 1, 0, 0, 0, 0, 32'h000);
    add_vec(0, 1, 32'h103, 1, 0, 1, 1, 0, 1, 0, 32'h102);
    add_vec(0, 1, 32'h104, 1, 0, 1, 2, 0, 1, 0, 32'h103);
    add_vec(0, 1, 32'h105, 1, 0, 1, 3, 0, 1, 0, 32'h104);
    add_vec(0, 1, 32'h106, 1, 0, 0, 4, 0, 1, 1, 32'h105);
    add_vec(0, 1, 32'h107, 1, 1, 0, 4, 0, 0, 0, 32'h105);
    add_vec(0, 1, 32'h108, 0, 0, 0, 4, 0, 0, 0, 32'h105);
    add_vec(1, 1, 32'h200, 0, 0, 0, 4, 0, 0, 0, 32'h105);
    add_vec(0, 1, 32'h201, 1, 0, 0, 0, 1, 0, 0, 32'h105);
    add_vec(0, 1, 32'h202, 1, 0, 1, 0, 0, 0, 0, 32'h105);
    add_vec(0, 0, 32'h203, 1, 0, 1, 1, 0, 1, 0, 32'h202);
    add_vec(0, 0, 32'h204, 1, 0, 1, 1, 0, 0, 0, 32'h202);
    add_vec(0, 1, 32'h205, 1, 0, 1, 1, 0, 0, 0, 32'h202);
    add_vec(1, 1, 32'h206, 1, 0, 1, 2, 0, 1, 0, 32'h205);
    add_vec(0, 1, 32'h207, 1, 0, 1, 3, 0, 1, 0, 32'h206);
    add_vec(0, 1, 32'h208, 1, 0, 0, 4, 0, 1, 1, 32'h207);
    add_vec(1, 1, 32'h209, 1, 1, 0, 4, 0, 0, 0, 32'h207);
    add_vec(0, 1, 32'h20a, 0, 0, 0, 4, 0, 0, 0, 32'h207);
    add_vec(0, 1, 32'h20b, 0, 0, 0, 4, 0, 0, 0, 32'h207);

    foreach (vecs[i]) begin
      @(negedge clk);
      chk($sformatf("vec%0d busy", i), b4, vecs[i].busy);
      chk($sformatf("vec%0d done", i), d4, vecs[i].done);
      chk($sformatf("vec%0d act_ready", i), r4, vecs[i].ready);
      chk($sformatf("vec%0d weight_address", i), a4, vecs[i].addr);
      chk($sformatf("vec%0d mac_clear", i), c4, vecs[i].clr);
      chk($sformatf("vec%0d mac_valid", i), v4, vecs[i].mv);
      chk($sformatf("vec%0d mac_last", i), l4, vecs[i].ml);
      chk($sformatf("vec%0d mac_act", i), m4, vecs[i].mact);
      start = vecs[i].start; act_valid = vecs[i].valid; act_data = vecs[i].data;
    end
`ifdef FC_SEQ_STALL_COUNT_EN
    chk("stall_cycles after stalled pass", s4, 2);
`endif

    // Reset in cycle 4 of a pass, then a clean pass afterwards.
    @(negedge clk); start = 1'b1; act_valid = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk); start = 1'b0;
    end
    @(negedge clk);
    chk("pre-reset addr", a4, 2);
    chk("pre-reset busy", b4, 1);
    rst = 1'b1;
    #1;
    chk("async reset addr", a4, 4);
    chk("async reset busy", b4, 0);
    chk("async reset ready", r4, 0);
    chk("async reset mac_valid", v4, 0);
    chk("async reset mac_act", m4, 0);
    @(negedge clk); rst = 1'b0;
    done_cnt = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (d4) done_cnt++;
    end
    chk("aborted pass done count", done_cnt, 0);
    start = 1'b1;
    beats = 0; done_cnt = 0; done_cyc = -1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk); start = 1'b0;
      if (v4) beats++;
      if (d4) begin
        done_cnt++;
        done_cyc = c;
      end
    end
    chk("post-reset pass beats", beats, 4);
    chk("post-reset pass done count", done_cnt, 1);
    chk("post-reset pass done cycle", done_cyc, 7);

    // INPUT_NODES=1: single handshake that is also the last row.
    do_reset();
    for (int c = 0; c <= 5; c++) begin
      @(negedge clk);
      case (c)
        1: begin chk("n1 mac_clear", c1, 1); chk("n1 clear addr", a1, 0); end
        2: begin chk("n1 ready", r1, 1); chk("n1 run addr", a1, 0); end
        3: begin
          chk("n1 mac_valid", v1, 1); chk("n1 mac_last", l1, 1);
          chk("n1 mac_act", m1, 32'h302); chk("n1 park addr", a1, 1); chk("n1 drain ready", r1, 0);
        end
        4: begin chk("n1 done", d1, 1); chk("n1 done busy", b1, 1); chk("n1 done mac_valid", v1, 0); end
        5: begin chk("n1 idle busy", b1, 0); chk("n1 idle done", d1, 0); end
        default: ;
      endcase
      start = (c == 0); act_valid = 1'b1; act_data = 32'h300 + 32'(c);
    end

    // Randomized traffic on INPUT_NODES=7 against the model.
    do_reset();
    model_reset();
    @(posedge clk); model_edge(1'b0, 1'b0, '0);
    for (int n = 0; n < 3000; n++) begin
      logic rs;
      @(negedge clk);
      chk("rand busy", b7, m_active);
      chk("rand done", d7, e_done());
      chk("rand act_ready", r7, e_ready());
      chk("rand weight_address", a7, e_addr());
      chk("rand mac_clear", c7, e_clear());
      chk("rand mac_valid", v7, m_pv);
      chk("rand mac_last", l7, m_pl);
      chk("rand mac_act", m7, m_act);
      if (m_pv != 0) chk("rand weight at beat", mem7_q, wfun(m_prow));
      if (m_prev_park != 0) chk("rand parked weight", mem7_q, 0);
`ifdef FC_SEQ_STALL_COUNT_EN
      chk("rand stall_cycles", s7, m_stall);
`endif
      start     = ($urandom_range(7) == 0);
      act_valid = ((n / 200) % 2 == 0) ? ($urandom_range(3) != 0) : ($urandom_range(3) == 0);
      act_data  = $urandom;
      rs        = ($urandom_range(299) == 0);
      if (rs) begin
        rst = 1'b1;
        #1;
        rst = 1'b0;
        model_reset();
      end
      @(posedge clk);
      model_edge(start, act_valid, act_data);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
